branch_predictor: RTL and testbench

//  Dynamic branch predictor for the 5-stage pipeline; replaces the static "BEQ always taken" choice in IF.

---
 rtl/branch_predictor_pkg.sv | 17 +
 rtl/branch_predictor_sat_counter.sv | 41 ++++
 rtl/branch_predictor.sv | 89 ++++++++
 tb/tb_branch_predictor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the dynamic branch predictor.
// Default sizes and the BEQ opcode used by IF to qualify lookups.
package branch_predictor_pkg;

    localparam int BP_ADDR_W     = 7;
    localparam int BP_ENTRIES    = 16;
    localparam int BP_CTR_WIDTH  = 2;
    localparam int BP_INIT_CTR   = 2;
    localparam int BP_STAT_WIDTH = 16;

    localparam logic [5:0] BEQ_OPCODE = 6'b000100;

    function automatic logic is_beq(input logic [5:0] opcode);
        return opcode == BEQ_OPCODE;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// One predictor table entry: saturating up/down counter.
// Clear loads INIT and wins over inc/dec; async active-low reset also loads INIT.
module sat_counter #(
    parameter int CTR_W = 2,
    parameter int INIT  = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CTR_W-1:0] cnt_o
);

    localparam logic [CTR_W-1:0] INIT_V = CTR_W'(INIT);
    localparam logic [CTR_W-1:0] MAX_V  = '1;

    logic [CTR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = INIT_V;
        end else if (inc_i && cnt_q != MAX_V) begin
            cnt_d = cnt_q + CTR_W'(1);
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - CTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= INIT_V;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped table of saturating counters; untagged, so PCs sharing low bits alias.
// Prediction and mispredict flag are combinational; table and statistics update on the clock.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_W   = BP_ADDR_W,
    parameter int ENTRIES  = BP_ENTRIES,
    parameter int CTR_W    = BP_CTR_WIDTH,
    parameter int INIT_CTR = BP_INIT_CTR,
    parameter int STAT_W   = BP_STAT_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    input  logic              lookup_branch_i,
    output logic              predict_taken_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic              upd_pred_i,
    output logic              mispredict_o,
    input  logic              clear_i,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [CTR_W-1:0] ctr [ENTRIES];
    logic             unused_pc_hi;

    assign lk_idx       = lookup_pc_i[IDX_W-1:0];
    assign up_idx       = upd_pc_i[IDX_W-1:0];
    assign unused_pc_hi = ^{lookup_pc_i[ADDR_W-1:IDX_W], upd_pc_i[ADDR_W-1:IDX_W]};

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        logic hit;
        assign hit = upd_valid_i && (up_idx == IDX_W'(g));
        sat_counter #(
            .CTR_W (CTR_W),
            .INIT  (INIT_CTR)
        ) u_ctr (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .clear_i (clear_i),
            .inc_i   (hit && upd_taken_i),
            .dec_i   (hit && !upd_taken_i),
            .cnt_o   (ctr[g])
        );
    end

    // Reads the registered entry, so a same-cycle update to this index is not visible yet.
    assign predict_taken_o = lookup_branch_i & ctr[lk_idx][CTR_W-1];
    assign mispredict_o    = upd_valid_i & (upd_pred_i ^ upd_taken_i);

    logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (clear_i) begin
            branch_cnt_d  = '0;
            mispred_cnt_d = '0;
        end else if (upd_valid_i) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + STAT_W'(1);
            end
            if (mispredict_o && mispred_cnt_q != '1) begin
                mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: default instance plus a STAT_W=4 instance on the same stimulus.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  lookup_pc = '0;
    logic        lookup_branch = 1'b0;
    logic        upd_valid = 1'b0;
    logic [6:0]  upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred = 1'b0;
    logic        clear = 1'b0;

    logic        pt_a, mp_a, pt_b, mp_b;
    logic [15:0] bc_a, mc_a;
    logic [3:0]  bc_b, mc_b;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    // Reference state: counter value per entry, and true (unsaturated) event counts.
    int tbl [16];
    int n_branch;
    int n_mispred;

    branch_predictor u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .lookup_pc_i(lookup_pc), .lookup_branch_i(lookup_branch), .predict_taken_o(pt_a),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken), .upd_pred_i(upd_pred),
        .mispredict_o(mp_a), .clear_i(clear), .branch_cnt_o(bc_a), .mispred_cnt_o(mc_a)
    );

    branch_predictor #(.STAT_W(4)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .lookup_pc_i(lookup_pc), .lookup_branch_i(lookup_branch), .predict_taken_o(pt_b),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken), .upd_pred_i(upd_pred),
        .mispredict_o(mp_b), .clear_i(clear), .branch_cnt_o(bc_b), .mispred_cnt_o(mc_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            foreach (tbl[i]) tbl[i] = 2;
            n_branch  = 0;
            n_mispred = 0;
        end else if (upd_valid) begin
            if (upd_taken) tbl[upd_pc % 16] = (tbl[upd_pc % 16] >= 3) ? 3 : tbl[upd_pc % 16] + 1;
            else           tbl[upd_pc % 16] = (tbl[upd_pc % 16] <= 0) ? 0 : tbl[upd_pc % 16] - 1;
            n_branch++;
            if (upd_pred != upd_taken) n_mispred++;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            int exp_pt, exp_mp;
            exp_pt = (lookup_branch && tbl[lookup_pc % 16] >= 2) ? 1 : 0;
            exp_mp = (upd_valid && (upd_pred != upd_taken)) ? 1 : 0;
            chk("predict_a", int'(pt_a), exp_pt);
            chk("predict_b", int'(pt_b), exp_pt);
            chk("mispred_a", int'(mp_a), exp_mp);
            chk("mispred_b", int'(mp_b), exp_mp);
            chk("brcnt_a", int'(bc_a), sat(n_branch, 16));
            chk("mpcnt_a", int'(mc_a), sat(n_mispred, 16));
            chk("brcnt_b", int'(bc_b), sat(n_branch, 4));
            chk("mpcnt_b", int'(mc_b), sat(n_mispred, 4));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [6:0] pc, input logic taken, input logic pred);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
        upd_pred  = pred;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic look(input string nm, input logic [6:0] pc, input int exp);
        lookup_branch = 1'b1;
        lookup_pc     = pc;
        #1;
        chk(nm, int'(pt_a), exp);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        checking = 1'b1;
        #1;
        chk("rst_brcnt", int'(bc_a), 0);
        chk("rst_mpcnt", int'(mc_a), 0);
        step();
        rst_n = 1'b1;
        step();
        look("rst_pred_pc9", 7'd9, 1);
        look("rst_pred_pc100", 7'd100, 1);

        // Drive pc=5 to strongly not-taken; pc=21 aliases, pc=6 untouched.
        repeat (3) do_upd(7'd5, 1'b0, 1'b0);
        look("nt_pc5", 7'd5, 0);
        look("alias_pc21", 7'd21, 0);
        look("other_pc6", 7'd6, 1);

        // pc=3: to 0, then 4x taken saturates at 3, two not-taken -> 1.
        repeat (2) do_upd(7'd3, 1'b0, 1'b0);
        look("pc3_zero", 7'd3, 0);
        repeat (4) do_upd(7'd3, 1'b1, 1'b1);
        do_upd(7'd3, 1'b0, 1'b0);
        look("pc3_sat_then_dec", 7'd3, 1);
        do_upd(7'd3, 1'b0, 1'b0);
        look("pc3_dec_again", 7'd3, 0);

        upd_valid = 1'b1; upd_pc = 7'd40; upd_pred = 1'b1; upd_taken = 1'b0;
        #1;
        chk("mispredict_comb", int'(mp_a), 1);
        step();
        upd_valid = 1'b0;
        chk("mp_brcnt", int'(bc_a), 12);
        chk("mp_mpcnt", int'(mc_a), 1);

        for (int i = 0; i < 20; i++) begin
            logic t;
            t = 1'($urandom);
            do_upd(7'($urandom), t, t);
        end
        chk("sat_brcnt_b", int'(bc_b), 15);
        chk("brcnt_a_32", int'(bc_a), 32);
        chk("mpcnt_b_1", int'(mc_b), 1);

        clear = 1'b1;
        do_upd(7'd5, 1'b0, 1'b1);
        clear = 1'b0;
        chk("clr_brcnt_a", int'(bc_a), 0);
        chk("clr_mpcnt_a", int'(mc_a), 0);
        chk("clr_brcnt_b", int'(bc_b), 0);
        for (int p = 0; p < 16; p++) look("clr_table", 7'(p), 1);

        for (int c = 0; c < 500; c++) begin
            lookup_pc     = 7'($urandom);
            lookup_branch = 1'($urandom);
            upd_valid     = ($urandom_range(0, 3) != 0);
            upd_pc        = 7'($urandom_range(0, 40));
            upd_taken     = ($urandom_range(0, 2) == 0);
            upd_pred      = 1'($urandom);
            clear         = (c < 480) && ($urandom_range(0, 63) == 0);
            step();
        end
        upd_valid = 1'b0;
        clear = 1'b0;
        repeat (3) do_upd(7'd7, 1'b0, 1'b1);

        #2 rst_n = 1'b0;
        #1;
        chk("async_brcnt", int'(bc_a), 0);
        chk("async_mpcnt", int'(mc_a), 0);
        look("async_pred_pc7", 7'd7, 1);
        step();
        rst_n = 1'b1;
        repeat (4) step();

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
